// File: rtl/ldpc_cn_sched.sv
// Min-sum check-node scheduler: collects one row of LLRs, then streams the extrinsics in order.
// Define LDPC_CN_OFFSET_EN for offset min-sum (emitted magnitude reduced by one, floored at 0).
module ldpc_cn_sched #(
  parameter int unsigned Q    = 8,
  parameter int unsigned DMAX = 16,
  parameter int unsigned SAT  = 63
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [Q-1:0] in_data_i,
  input  logic         in_last_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [Q-1:0] out_data_o,
  output logic         out_last_o,
  output logic         busy_o,
  output logic         deg_err_o
);
  localparam int unsigned   IW      = (DMAX > 1) ? $clog2(DMAX) : 1;
  localparam logic [Q-1:0]  SatMag  = Q'(SAT);
  localparam logic [Q:0]    SatWide = (Q+1)'(SAT);
  localparam logic [IW-1:0] LastIdx = IW'(DMAX - 1);

  typedef enum logic [1:0] {StIdle, StCollect, StEmit} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d, rd_q, rd_d, idx1_q, idx1_d;
  logic [Q-1:0]    min1_q, min1_d, min2_q, min2_d;
  logic            parity_q, parity_d;
  logic [DMAX-1:0] sgn_buf_q, sgn_buf_d;
  logic            out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [Q-1:0]    out_data_q, out_data_d;
  logic            deg_err_q, deg_err_d;

  logic            sgn, idle, forced, sgn0, upd_par, base_par;
  logic [Q:0]      x_ext, abs_x;
  logic [Q-1:0]    mag, base_min1, base_min2, upd_min1, upd_min2;
  logic [IW-1:0]   wr_idx, base_idx, upd_idx, nxt_rd;

  function automatic logic [Q-1:0] emit_val(input logic [Q-1:0] m, input logic s);
    logic [Q-1:0] mv;
`ifdef LDPC_CN_OFFSET_EN
    mv = (m == '0) ? '0 : m - Q'(1);
`else
    mv = m;
`endif
    return s ? -mv : mv;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    idx1_d      = idx1_q;
    min1_d      = min1_q;
    min2_d      = min2_q;
    parity_d    = parity_q;
    sgn_buf_d   = sgn_buf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    deg_err_d   = 1'b0;

    // Widen by one bit so that |-2^(Q-1)| is representable before saturation.
    sgn   = in_data_i[Q-1];
    x_ext = {sgn, in_data_i};
    abs_x = sgn ? -x_ext : x_ext;
    mag   = (abs_x > SatWide) ? SatMag : abs_x[Q-1:0];

    // The first beat of a row sees freshly initialised trackers.
    idle      = (state_q == StIdle);
    wr_idx    = idle ? '0 : cnt_q;
    base_min1 = idle ? SatMag : min1_q;
    base_min2 = idle ? SatMag : min2_q;
    base_idx  = idle ? '0 : idx1_q;
    base_par  = idle ? 1'b0 : parity_q;

    upd_min1 = base_min1;
    upd_min2 = base_min2;
    upd_idx  = base_idx;
    if (mag < base_min1) begin
      upd_min2 = base_min1;
      upd_min1 = mag;
      upd_idx  = wr_idx;
    end else if (mag < base_min2) begin
      upd_min2 = mag;
    end
    upd_par = base_par ^ sgn;

    forced = (wr_idx == LastIdx);
    sgn0   = (wr_idx == '0) ? sgn : sgn_buf_q[0];
    nxt_rd = rd_q + IW'(1);

    case (state_q)
      StIdle, StCollect: begin
        if (in_valid_i) begin
          sgn_buf_d[wr_idx] = sgn;
          min1_d   = upd_min1;
          min2_d   = upd_min2;
          idx1_d   = upd_idx;
          parity_d = upd_par;
          if (in_last_i || forced) begin
            // Entry 0 is computed from the post-update trackers so it is valid next cycle.
            state_d     = StEmit;
            cnt_d       = wr_idx;
            rd_d        = '0;
            out_valid_d = 1'b1;
            out_data_d  = emit_val((upd_idx == '0) ? upd_min2 : upd_min1, sgn0 ^ upd_par);
            out_last_d  = (wr_idx == '0);
            deg_err_d   = forced && !in_last_i;
          end else begin
            state_d = StCollect;
            cnt_d   = wr_idx + IW'(1);
          end
        end
      end
      StEmit: begin
        if (out_valid_q && out_ready_i) begin
          if (out_last_q) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
          end else begin
            rd_d       = nxt_rd;
            out_data_d = emit_val((nxt_rd == idx1_q) ? min2_q : min1_q,
                                  sgn_buf_q[nxt_rd] ^ parity_q);
            out_last_d = (nxt_rd == cnt_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rd_q        <= '0;
      idx1_q      <= '0;
      min1_q      <= '0;
      min2_q      <= '0;
      parity_q    <= 1'b0;
      sgn_buf_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      deg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      idx1_q      <= idx1_d;
      min1_q      <= min1_d;
      min2_q      <= min2_d;
      parity_q    <= parity_d;
      sgn_buf_q   <= sgn_buf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      deg_err_q   <= deg_err_d;
    end
  end

  assign in_ready_o  = (state_q != StEmit);
  assign busy_o      = (state_q != StIdle);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign deg_err_o   = deg_err_q;

endmodule

// File: tb/tb_ldpc_cn_sched.sv
// Bench for ldpc_cn_sched: directed and random rows against an extrinsic-min reference model.
module tb_ldpc_cn_sched;
  localparam int Q    = 8;
  localparam int DMAX = 16;
  localparam int SAT  = 63;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [Q-1:0] in_data_i = '0;
  logic         in_last_i = 1'b0;
  logic         out_valid_o;
  logic         out_ready_i = 1'b0;
  logic [Q-1:0] out_data_o;
  logic         out_last_o;
  logic         busy_o;
  logic         deg_err_o;

  always #5 clk = ~clk;

  ldpc_cn_sched #(.Q(Q), .DMAX(DMAX), .SAT(SAT)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .in_last_i  (in_last_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .out_last_o (out_last_o),
    .busy_o     (busy_o),
    .deg_err_o  (deg_err_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int row_q[$];
  int exp_q[$];
  int exp_last_q[$];
  int got_q[$];
  int glast_q[$];
  int acc_cyc_q[$];
  int cyc, first_valid_cyc, last_acc_cyc, deg_cnt, stall_err, acc_at_done, done_cyc, emit_low;
  int timed_out;

  // Extrinsic for entry i: min magnitude and sign product over every other entry.
  task automatic model(input int n);
    exp_q.delete();
    exp_last_q.delete();
    for (int i = 0; i < n; i++) begin
      int m = SAT;
      int s = 0;
      for (int j = 0; j < n; j++) begin
        if (j != i) begin
          int a = (row_q[j] < 0) ? -row_q[j] : row_q[j];
          if (a > SAT) a = SAT;
          if (a < m) m = a;
          if (row_q[j] < 0) s ^= 1;
        end
      end
`ifdef LDPC_CN_OFFSET_EN
      if (m > 0) m = m - 1;
`endif
      exp_q.push_back(s ? -m : m);
      exp_last_q.push_back(i == n - 1);
    end
  endtask

  // Drives row_q and records outputs; mode 0: ready high, 1: ready 1,0,0,1, 2: random gaps.
  task automatic run_row(input bit use_last, input int mode, input int max_out);
    int  sent = 0;
    bit  done = 1'b0;
    bit  prev_stall = 1'b0;
    int  prev_data = 0;
    int  prev_last = 0;
    bit  iv, ordy;
    got_q.delete();
    glast_q.delete();
    acc_cyc_q.delete();
    cyc = 0; first_valid_cyc = -1; last_acc_cyc = -1; deg_cnt = 0; stall_err = 0;
    acc_at_done = -1; done_cyc = -1; emit_low = 0;
    while (!(sent == row_q.size() && done) && cyc < 400) begin
      @(negedge clk);
      if (prev_stall && ($signed(out_data_o) != prev_data || int'(out_last_o) != prev_last))
        stall_err++;
      if (out_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (deg_err_o) deg_cnt++;
      if (!in_ready_o) emit_low++;
      iv = (sent < row_q.size()) && (mode != 2 || $urandom_range(0, 3) != 0);
      case (mode)
        1:       ordy = (cyc % 4 == 0) || (cyc % 4 == 3);
        2:       ordy = ($urandom_range(0, 2) != 0);
        default: ordy = 1'b1;
      endcase
      in_valid_i  = iv;
      in_data_i   = iv ? Q'(row_q[sent]) : Q'($urandom);
      in_last_i   = iv && use_last && (sent == row_q.size() - 1);
      out_ready_i = ordy;
      if (iv && in_ready_o) begin
        sent++;
        last_acc_cyc = cyc;
        acc_cyc_q.push_back(cyc);
      end
      if (out_valid_o && ordy) begin
        got_q.push_back($signed(out_data_o));
        glast_q.push_back(int'(out_last_o));
        if (out_last_o) begin
          done = 1'b1;
          done_cyc = cyc;
          acc_at_done = sent;
        end
      end
      if (max_out > 0 && got_q.size() == max_out) done = 1'b1;
      prev_stall = out_valid_o && !ordy;
      prev_data  = $signed(out_data_o);
      prev_last  = int'(out_last_o);
      @(posedge clk);
      cyc++;
    end
    timed_out = (sent == row_q.size() && done) ? 0 : 1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_i = 1'b1; in_valid_i = 1'b0; in_last_i = 1'b0; out_ready_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid_o !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid_o); else n_pass++;
    n_checks++; if (out_data_o !== '0) $display("FAIL rst_out_data: got %0d expected 0", out_data_o); else n_pass++;
    n_checks++; if (out_last_o !== 1'b0) $display("FAIL rst_out_last: got %b expected 0", out_last_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy_o); else n_pass++;
    n_checks++; if (deg_err_o !== 1'b0) $display("FAIL rst_deg_err: got %b expected 0", deg_err_o); else n_pass++;
    n_checks++; if (in_ready_o !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready_o); else n_pass++;
    rst_i = 1'b0;
  endtask

  task automatic test_basic();
    row_q = '{5, -3, 10, -7};
    model(4);
    run_row(1'b1, 0, 0);
    n_checks++; if (timed_out != 0) $display("FAIL basic_timeout: got %0d expected 0", timed_out); else n_pass++;
    n_checks++; if (first_valid_cyc - last_acc_cyc != 1)
      $display("FAIL basic_latency: got %0d expected 1", first_valid_cyc - last_acc_cyc); else n_pass++;
    n_checks++; if (got_q.size() != exp_q.size())
      $display("FAIL basic_count: got %0d expected %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] != exp_q[i]) $display("FAIL basic_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); else n_pass++;
      n_checks++; if (glast_q[i] != exp_last_q[i]) $display("FAIL basic_last[%0d]: got %0d expected %0d", i, glast_q[i], exp_last_q[i]); else n_pass++;
    end
  endtask

  task automatic test_saturation_tie();
    for (int r = 0; r < 2; r++) begin
      if (r == 0) row_q = '{-128, 100};
      else        row_q = '{4, 4, -9};
      model(row_q.size());
      run_row(1'b1, 0, 0);
      n_checks++; if (timed_out != 0) $display("FAIL sat_timeout[%0d]: got %0d expected 0", r, timed_out); else n_pass++;
      n_checks++; if (got_q.size() != exp_q.size())
        $display("FAIL sat_count[%0d]: got %0d expected %0d", r, got_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_checks++; if (got_q[i] != exp_q[i]) $display("FAIL sat_data[%0d][%0d]: got %0d expected %0d", r, i, got_q[i], exp_q[i]); else n_pass++;
        n_checks++; if (glast_q[i] != exp_last_q[i]) $display("FAIL sat_last[%0d][%0d]: got %0d expected %0d", r, i, glast_q[i], exp_last_q[i]); else n_pass++;
      end
    end
  endtask

  task automatic test_degree_overflow();
    row_q.delete();
    for (int i = 0; i < DMAX + 1; i++) row_q.push_back(1);
    model(DMAX);
    run_row(1'b0, 0, 0);
    n_checks++; if (timed_out != 0) $display("FAIL ovf_timeout: got %0d expected 0", timed_out); else n_pass++;
    n_checks++; if (deg_cnt != 1) $display("FAIL ovf_deg_err_pulses: got %0d expected 1", deg_cnt); else n_pass++;
    n_checks++; if (acc_at_done != DMAX) $display("FAIL ovf_accepted: got %0d expected %0d", acc_at_done, DMAX); else n_pass++;
    n_checks++; if (emit_low != DMAX) $display("FAIL ovf_ready_low_cycles: got %0d expected %0d", emit_low, DMAX); else n_pass++;
    n_checks++; if (acc_cyc_q.size() != DMAX + 1 || acc_cyc_q[acc_cyc_q.size() - 1] != done_cyc + 1)
      $display("FAIL ovf_extra_beat_cycle: got %0d expected %0d", acc_cyc_q[acc_cyc_q.size() - 1], done_cyc + 1); else n_pass++;
    n_checks++; if (got_q.size() != exp_q.size())
      $display("FAIL ovf_count: got %0d expected %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] != exp_q[i]) $display("FAIL ovf_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); else n_pass++;
      n_checks++; if (glast_q[i] != exp_last_q[i]) $display("FAIL ovf_last[%0d]: got %0d expected %0d", i, glast_q[i], exp_last_q[i]); else n_pass++;
    end
    apply_reset();
    // Explicit last on the DMAX-th beat is a normal end of row.
    row_q.delete();
    for (int i = 0; i < DMAX; i++) row_q.push_back(int'($urandom_range(0, 255)) - 128);
    model(DMAX);
    run_row(1'b1, 0, 0);
    n_checks++; if (deg_cnt != 0) $display("FAIL full_last_deg_err: got %0d expected 0", deg_cnt); else n_pass++;
    n_checks++; if (got_q.size() != exp_q.size())
      $display("FAIL full_last_count: got %0d expected %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] != exp_q[i]) $display("FAIL full_last_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    row_q = '{5, -3, 10, -7};
    model(4);
    run_row(1'b1, 1, 0);
    n_checks++; if (timed_out != 0) $display("FAIL bp_timeout: got %0d expected 0", timed_out); else n_pass++;
    n_checks++; if (stall_err != 0) $display("FAIL bp_stable: got %0d changes expected 0", stall_err); else n_pass++;
    n_checks++; if (got_q.size() != exp_q.size())
      $display("FAIL bp_count: got %0d expected %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] != exp_q[i]) $display("FAIL bp_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); else n_pass++;
      n_checks++; if (glast_q[i] != exp_last_q[i]) $display("FAIL bp_last[%0d]: got %0d expected %0d", i, glast_q[i], exp_last_q[i]); else n_pass++;
    end
  endtask

  task automatic test_degree1();
    row_q = '{-20};
    model(1);
    run_row(1'b1, 0, 0);
    n_checks++; if (got_q.size() != 1) $display("FAIL deg1_count: got %0d expected 1", got_q.size()); else n_pass++;
    if (got_q.size() > 0) begin
      n_checks++; if (got_q[0] != exp_q[0]) $display("FAIL deg1_data: got %0d expected %0d", got_q[0], exp_q[0]); else n_pass++;
      n_checks++; if (glast_q[0] != 1) $display("FAIL deg1_last: got %0d expected 1", glast_q[0]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    row_q = '{-30, 12, 7};
    run_row(1'b1, 0, 0);
    row_q = '{9, -40, -2, 25, 1};
    model(5);
    run_row(1'b1, 0, 0);
    n_checks++; if (acc_cyc_q.size() == 0 || acc_cyc_q[0] != 0)
      $display("FAIL b2b_first_accept: got cycle %0d expected 0", (acc_cyc_q.size() > 0) ? acc_cyc_q[0] : -1); else n_pass++;
    n_checks++; if (got_q.size() != exp_q.size())
      $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] != exp_q[i]) $display("FAIL b2b_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_emit();
    row_q = '{5, -3, 10, -7};
    run_row(1'b1, 0, 2);
    n_checks++; if (got_q.size() != 2) $display("FAIL midrst_outputs_before: got %0d expected 2", got_q.size()); else n_pass++;
    @(negedge clk);
    rst_i = 1'b1; in_valid_i = 1'b0; in_last_i = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid_o !== 1'b0) $display("FAIL midrst_out_valid: got %b expected 0", out_valid_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy_o); else n_pass++;
    n_checks++; if (in_ready_o !== 1'b1) $display("FAIL midrst_in_ready: got %b expected 1", in_ready_o); else n_pass++;
    rst_i = 1'b0;
    row_q = '{2, -1};
    model(2);
    run_row(1'b1, 0, 0);
    n_checks++; if (got_q.size() != exp_q.size())
      $display("FAIL midrst_count: got %0d expected %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] != exp_q[i]) $display("FAIL midrst_data[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); else n_pass++;
      n_checks++; if (glast_q[i] != exp_last_q[i]) $display("FAIL midrst_last[%0d]: got %0d expected %0d", i, glast_q[i], exp_last_q[i]); else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 20; r++) begin
      int  len = $urandom_range(1, DMAX);
      bit  use_last = (len < DMAX) ? 1'b1 : 1'($urandom_range(0, 1));
      row_q.delete();
      for (int i = 0; i < len; i++) row_q.push_back(int'($urandom_range(0, 255)) - 128);
      model(len);
      run_row(use_last, 2, 0);
      n_checks++; if (timed_out != 0) $display("FAIL rnd_timeout[%0d]: got %0d expected 0", r, timed_out); else n_pass++;
      n_checks++; if (deg_cnt != (use_last ? 0 : 1))
        $display("FAIL rnd_deg_err[%0d]: got %0d expected %0d", r, deg_cnt, use_last ? 0 : 1); else n_pass++;
      n_checks++; if (stall_err != 0) $display("FAIL rnd_stable[%0d]: got %0d changes expected 0", r, stall_err); else n_pass++;
      n_checks++; if (got_q.size() != exp_q.size())
        $display("FAIL rnd_count[%0d]: got %0d expected %0d", r, got_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        n_checks++; if (got_q[i] != exp_q[i]) $display("FAIL rnd_data[%0d][%0d]: got %0d expected %0d", r, i, got_q[i], exp_q[i]); else n_pass++;
        n_checks++; if (glast_q[i] != exp_last_q[i]) $display("FAIL rnd_last[%0d][%0d]: got %0d expected %0d", r, i, glast_q[i], exp_last_q[i]); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation_tie();
    test_degree_overflow();
    test_backpressure();
    test_degree1();
    test_back_to_back();
    test_reset_mid_emit();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
